// File: rtl/des_subkey_sequencer.sv
// Iterative DES key schedule: one rotating C/D pair feeds a shared PC-2 and streams
// K1..K16 (or K16..K1) one subkey per valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for a key, key_ready=1
// RUN   | streaming subkeys, C/D hold the schedule point of the subkey on offer
module des_subkey_sequencer #(
  parameter bit PARITY_CHECK = 1'b1,
  parameter bit OUT_REG      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [63:0] key,
  input  logic        decrypt,
  input  logic        abort,
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic [47:0] subkey,
  output logic [3:0]  sk_round,
  output logic        sk_last,
  output logic        key_parity_err
);

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_nx;
  logic [55:0] cd, cd_nx;
  logic [3:0]  idx, idx_nx;
  logic        dec, dec_nx;
  logic        perr, perr_nx;
  logic [4:0]  idx_ext;

  // Vectors use DES numbering: bit 1 is the MSB.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] v);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[47-i] = v[56-PC2[i]];
    return r;
  endfunction

  function automatic logic [55:0] rotl(input logic [55:0] v, input logic two);
    logic [27:0] c, d;
    c = v[55:28];
    d = v[27:0];
    if (two) return {c[25:0], c[27:26], d[25:0], d[27:26]};
    return {c[26:0], c[27], d[26:0], d[27]};
  endfunction

  function automatic logic [55:0] rotr(input logic [55:0] v, input logic two);
    logic [27:0] c, d;
    c = v[55:28];
    d = v[27:0];
    if (two) return {c[1:0], c[27:2], d[1:0], d[27:2]};
    return {c[0], c[27:1], d[0], d[27:1]};
  endfunction

  // Shift schedule S[n]: only rounds 1, 2, 9 and 16 shift by one.
  function automatic logic shift_two(input logic [4:0] n);
    return !(n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16);
  endfunction

  function automatic logic even_byte(input logic [63:0] k);
    logic e;
    e = 1'b0;
    for (int b = 0; b < 8; b++) if (!(^k[8*b +: 8])) e = 1'b1;
    return e;
  endfunction

  assign idx_ext   = {1'b0, idx};
  assign key_ready = (state == IDLE);
  assign sk_valid  = (state == RUN);

  always_comb begin
    state_nx = state;
    cd_nx    = cd;
    idx_nx   = idx;
    dec_nx   = dec;
    perr_nx  = perr;
    case (state)
      IDLE: begin
        if (key_valid) begin
          state_nx = RUN;
          cd_nx    = decrypt ? pc1(key) : rotl(pc1(key), 1'b0);
          idx_nx   = 4'd0;
          dec_nx   = decrypt;
          perr_nx  = PARITY_CHECK ? even_byte(key) : 1'b0;
        end
      end
      RUN: begin
        if (abort || (sk_ready && idx == 4'd15)) begin
          state_nx = IDLE;
        end else if (sk_ready) begin
          idx_nx = idx + 4'd1;
          // Decrypt walks the schedule backwards, undoing S[16], S[15], ...
          cd_nx  = dec ? rotr(cd, shift_two(5'd16 - idx_ext))
                       : rotl(cd, shift_two(idx_ext + 5'd2));
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cd    <= '0;
      idx   <= '0;
      dec   <= 1'b0;
      perr  <= 1'b0;
    end else begin
      state <= state_nx;
      cd    <= cd_nx;
      idx   <= idx_nx;
      dec   <= dec_nx;
      perr  <= perr_nx;
    end
  end

  assign key_parity_err = perr;

  generate
    if (OUT_REG) begin : g_oreg
      logic [47:0] subkey_q;
      logic [3:0]  round_q;
      logic        last_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          subkey_q <= '0;
          round_q  <= '0;
          last_q   <= 1'b0;
        end else begin
          subkey_q <= pc2(cd_nx);
          round_q  <= dec_nx ? 4'd15 - idx_nx : idx_nx;
          last_q   <= (idx_nx == 4'd15);
        end
      end
      assign subkey   = subkey_q;
      assign sk_round = round_q;
      assign sk_last  = last_q;
    end else begin : g_comb
      assign subkey   = pc2(cd);
      assign sk_round = dec ? 4'd15 - idx : idx;
      assign sk_last  = (idx == 4'd15);
    end
  endgenerate

endmodule
